qspi_cmd_arbiter: RTL and testbench



---
 rtl/qspi_arb_pkg.sv | 24 ++
 rtl/qspi_cmd_arbiter_rr_arbiter.sv | 35 +++
 rtl/qspi_cmd_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_qspi_cmd_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI command arbiter: field widths, default
// descriptor geometry and the arbiter FSM state encoding.
package qspi_arb_pkg;

   localparam int INSTR_W    = 8;
   localparam int DUMMY_W    = 4;
   localparam int DEF_ADDR_W = 24;
   localparam int DEF_LEN_W  = 16;

   // Descriptor layout {instr, addr, dummy, len}, len at bit 0, default widths
   localparam int DESC_LEN_OFF   = 0;
   localparam int DESC_DUMMY_OFF = DESC_LEN_OFF + DEF_LEN_W;
   localparam int DESC_ADDR_OFF  = DESC_DUMMY_OFF + DUMMY_W;
   localparam int DESC_INSTR_OFF = DESC_ADDR_OFF + DEF_ADDR_W;
   localparam int DESC_W         = DESC_INSTR_OFF + INSTR_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_RELEASE   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/qspi_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker. Searches from last_owner+1 upward,
// wrapping modulo N; the first asserted request wins. Reusable for any
// shared resource that keeps its own last-owner register.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_owner,
   output logic [N-1:0]     grant_onehot,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   // Rotating priority scan; the first hit blocks all later candidates
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      grant_onehot = '0;
      grant_idx    = '0;
      any          = 1'b0;
      cand         = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IDX_W'((int'(last_owner) + i) % N);
         if (!any && req[cand]) begin
            any                = 1'b1;
            grant_idx          = cand;
            grant_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/qspi_cmd_arbiter.sv
// Shares one QSPI phase engine among NUM_REQ command requesters.
// Round-robin grant, latch of the winner's descriptor, one-cycle engine
// start, wait for engine done, one-cycle ack to the owner.
// Optional watchdog: define QSPI_ARB_TIMEOUT_EN to abort a transfer whose
// engine never reports done within TIMEOUT_CYC cycles.
module qspi_cmd_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*INSTR_W-1:0]   cmd_instr,
   input  logic [NUM_REQ*ADDR_W-1:0]    cmd_addr,
   input  logic [NUM_REQ*DUMMY_W-1:0]   cmd_dummy,
   input  logic [NUM_REQ*LEN_W-1:0]     cmd_len,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           ack,
   output logic [$clog2(NUM_REQ)-1:0]   owner,
   output logic                         eng_start,
   output logic [INSTR_W-1:0]           eng_instr,
   output logic [ADDR_W-1:0]            eng_addr,
   output logic [DUMMY_W-1:0]           eng_dummy,
   output logic [LEN_W-1:0]             eng_len,
   input  logic                         eng_done,
   output logic                         eng_abort,
   output logic                         timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_owner_q, last_owner_d;
   logic               eng_start_q, eng_start_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DUMMY_W-1:0] dummy_q, dummy_d;
   logic [LEN_W-1:0]   len_q, len_d;

   logic [NUM_REQ-1:0] rr_onehot;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_any;

   // Per-requester views of the packed descriptor buses
   logic [INSTR_W-1:0] instr_a [NUM_REQ];
   logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
   logic [DUMMY_W-1:0] dummy_a [NUM_REQ];
   logic [LEN_W-1:0]   len_a   [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign instr_a[g] = cmd_instr[g*INSTR_W +: INSTR_W];
      assign addr_a[g]  = cmd_addr[g*ADDR_W +: ADDR_W];
      assign dummy_a[g] = cmd_dummy[g*DUMMY_W +: DUMMY_W];
      assign len_a[g]   = cmd_len[g*LEN_W +: LEN_W];
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req          (req),
      .last_owner   (last_owner_q),
      .grant_onehot (rr_onehot),
      .grant_idx    (rr_idx),
      .any          (rr_any)
   );

`ifdef QSPI_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             eng_abort_q, eng_abort_d;
   logic             timeout_err_q, timeout_err_d;
`else
   localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
`endif

   // Next-state and next-output logic of the arbitration FSM
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      ack_d        = '0;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      eng_start_d  = 1'b0;
      instr_d      = instr_q;
      addr_d       = addr_q;
      dummy_d      = dummy_q;
      len_d        = len_q;
`ifdef QSPI_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
      eng_abort_d   = 1'b0;
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // req is only looked at here; grant, owner, descriptor and the
            // start pulse all become visible together on the next cycle.
            if (rr_any) begin
               state_d      = ST_LAUNCH;
               gnt_d        = rr_onehot;
               owner_d      = rr_idx;
               last_owner_d = rr_idx;
               eng_start_d  = 1'b1;
               instr_d      = instr_a[rr_idx];
               addr_d       = addr_a[rr_idx];
               dummy_d      = dummy_a[rr_idx];
               len_d        = len_a[rr_idx];
            end
         end
         ST_LAUNCH: begin
            // eng_done here coincides with eng_start and is ignored
            state_d = ST_WAIT_DONE;
`ifdef QSPI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT_DONE: begin
            if (eng_done) begin
               state_d = ST_RELEASE;
               ack_d   = gnt_q;
            end
`ifdef QSPI_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d       = ST_RELEASE;
               ack_d         = gnt_q;
               eng_abort_d   = 1'b1;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; descriptor regs also clear on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         ack_q        <= '0;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
         eng_start_q  <= 1'b0;
         instr_q      <= '0;
         addr_q       <= '0;
         dummy_q      <= '0;
         len_q        <= '0;
`ifdef QSPI_ARB_TIMEOUT_EN
         cnt_q         <= '0;
         eng_abort_q   <= 1'b0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         eng_start_q  <= eng_start_d;
         instr_q      <= instr_d;
         addr_q       <= addr_d;
         dummy_q      <= dummy_d;
         len_q        <= len_d;
`ifdef QSPI_ARB_TIMEOUT_EN
         cnt_q         <= cnt_d;
         eng_abort_q   <= eng_abort_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign ack       = ack_q;
   assign owner     = owner_q;
   assign eng_start = eng_start_q;
   assign eng_instr = instr_q;
   assign eng_addr  = addr_q;
   assign eng_dummy = dummy_q;
   assign eng_len   = len_q;

`ifdef QSPI_ARB_TIMEOUT_EN
   assign eng_abort   = eng_abort_q;
   assign timeout_err = timeout_err_q;
`else
   assign eng_abort   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_cmd_arbiter.sv
// Directed bench for qspi_cmd_arbiter with two requesters. Expected values
// are hand-derived from the arbiter's cycle behaviour. The timeout scenario
// is compiled in only when QSPI_ARB_TIMEOUT_EN is defined.
module tb_qspi_cmd_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 24;
   localparam int LEN_W   = 16;
`ifdef QSPI_ARB_TIMEOUT_EN
   localparam int TIMEOUT_CYC = 16;
`else
   localparam int TIMEOUT_CYC = 4096;
`endif

   localparam logic [23:0] ADDR0 = 24'h123456;
   localparam logic [23:0] ADDR1 = 24'hABCDEF;

   logic                clk = 1'b0;
   logic                reset;
   logic [1:0]          req;
   logic [15:0]         cmd_instr;
   logic [47:0]         cmd_addr;
   logic [7:0]          cmd_dummy;
   logic [31:0]         cmd_len;
   logic [1:0]          gnt;
   logic [1:0]          ack;
   logic [0:0]          owner;
   logic                eng_start;
   logic [7:0]          eng_instr;
   logic [ADDR_W-1:0]   eng_addr;
   logic [3:0]          eng_dummy;
   logic [LEN_W-1:0]    eng_len;
   logic                eng_done;
   logic                eng_abort;
   logic                timeout_err;

   int vectors     = 0;
   int miscompares = 0;
   logic two_hot_seen = 1'b0;
   logic abort_seen   = 1'b0;

   qspi_cmd_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .ADDR_W      (ADDR_W),
      .LEN_W       (LEN_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .cmd_instr   (cmd_instr),
      .cmd_addr    (cmd_addr),
      .cmd_dummy   (cmd_dummy),
      .cmd_len     (cmd_len),
      .gnt         (gnt),
      .ack         (ack),
      .owner       (owner),
      .eng_start   (eng_start),
      .eng_instr   (eng_instr),
      .eng_addr    (eng_addr),
      .eng_dummy   (eng_dummy),
      .eng_len     (eng_len),
      .eng_done    (eng_done),
      .eng_abort   (eng_abort),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Background watch: grant must never be two-hot; abort/error activity
   always @(negedge clk) begin
      if (!$onehot0(gnt)) two_hot_seen = 1'b1;
      if (eng_abort || timeout_err) abort_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Run one transfer starting from IDLE or from the cycle gnt rises
   task automatic run_xfer(input int idx, input logic [23:0] exp_addr, input int wait_cyc,
                           input logic [1:0] drop, input string tag);
      int n;
      n = 0;
      while (gnt == 2'b00 && n < 16) begin
         tick();
         n++;
      end
      check({tag, ":gnt"},   64'(gnt),       64'(2'b01 << idx));
      check({tag, ":owner"}, 64'(owner),     64'(idx));
      check({tag, ":start"}, 64'(eng_start), 64'd1);
      check({tag, ":addr"},  64'(eng_addr),  64'(exp_addr));
      tick();
      check({tag, ":start_low"}, 64'(eng_start), 64'd0);
      repeat (wait_cyc) tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check({tag, ":ack"}, 64'(ack), 64'(2'b01 << idx));
      req = req & ~drop;
      tick();
      check({tag, ":ack_low"}, 64'(ack), 64'd0);
      check({tag, ":gnt_low"}, 64'(gnt), 64'd0);
   endtask

   initial begin
      reset     = 1'b1;
      req       = 2'b00;
      eng_done  = 1'b0;
      cmd_instr = {8'h6B, 8'hEB};
      cmd_addr  = {ADDR1, ADDR0};
      cmd_dummy = {4'd8, 4'd6};
      cmd_len   = {16'd256, 16'd16};
      #23;
      check("rst:gnt",   64'(gnt),       64'd0);
      check("rst:ack",   64'(ack),       64'd0);
      check("rst:owner", 64'(owner),     64'd0);
      check("rst:start", 64'(eng_start), 64'd0);
      check("rst:addr",  64'(eng_addr),  64'd0);
      check("rst:len",   64'(eng_len),   64'd0);
      reset = 1'b0;
      tick();

      // 1: single request, fixed latency and descriptor latch
      req = 2'b01;
      tick();
      check("t1:gnt",   64'(gnt),       64'd1);
      check("t1:start", 64'(eng_start), 64'd1);
      check("t1:instr", 64'(eng_instr), 64'hEB);
      check("t1:addr",  64'(eng_addr),  64'h123456);
      check("t1:dummy", 64'(eng_dummy), 64'd6);
      check("t1:len",   64'(eng_len),   64'd16);
      tick();
      check("t1:start_low", 64'(eng_start), 64'd0);
      repeat (38) tick();
      check("t1:no_early_ack", 64'(ack), 64'd0);
      check("t1:gnt_held",     64'(gnt), 64'd1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("t1:ack", 64'(ack), 64'd1);
      req = 2'b00;
      tick();
      check("t1:ack_low", 64'(ack), 64'd0);
      check("t1:gnt_low", 64'(gnt), 64'd0);
      check("t1:addr_kept", 64'(eng_addr), 64'h123456);

      // 2: both held from reset -> 0,1,0,1
      apply_reset();
      req = 2'b11;
      run_xfer(0, ADDR0, 3, 2'b00, "t2a");
      run_xfer(1, ADDR1, 2, 2'b00, "t2b");
      run_xfer(0, ADDR0, 5, 2'b00, "t2c");
      run_xfer(1, ADDR1, 1, 2'b11, "t2d");

      // 3: descriptor stability and immediate re-grant of a late requester
      req = 2'b10;
      tick();
      check("t3:gnt1", 64'(gnt), 64'd2);
      tick();
      cmd_addr[47:24] = 24'hFFFFFF;
      req[0] = 1'b1;
      repeat (3) tick();
      check("t3:addr_stable", 64'(eng_addr), 64'(ADDR1));
      check("t3:gnt_stable",  64'(gnt),      64'd2);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("t3:ack1", 64'(ack), 64'd2);
      req[1] = 1'b0;
      tick();
      tick();
      check("t3:gnt0_next", 64'(gnt), 64'd1);
      run_xfer(0, ADDR0, 2, 2'b01, "t3b");

      // 4: eng_done in IDLE and in LAUNCH is ignored
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("t4:idle_ack", 64'(ack), 64'd0);
      check("t4:idle_gnt", 64'(gnt), 64'd0);
      tick();
      req = 2'b01;
      tick();
      check("t4:gnt",   64'(gnt),       64'd1);
      check("t4:start", 64'(eng_start), 64'd1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("t4:launch_ack", 64'(ack), 64'd0);
      check("t4:launch_gnt", 64'(gnt), 64'd1);
      repeat (3) tick();
      check("t4:still_waiting", 64'(ack), 64'd0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("t4:ack", 64'(ack), 64'd1);
      req = 2'b00;
      tick();
      check("t4:gnt_low", 64'(gnt), 64'd0);

      // 5: asynchronous reset during WAIT_DONE, rr pointer restored
      req = 2'b01;
      tick();
      tick();
      repeat (3) tick();
      #3;
      reset = 1'b1;
      #1;
      check("t5:gnt",   64'(gnt),       64'd0);
      check("t5:owner", 64'(owner),     64'd0);
      check("t5:addr",  64'(eng_addr),  64'd0);
      check("t5:instr", 64'(eng_instr), 64'd0);
      check("t5:ack",   64'(ack),       64'd0);
      req = 2'b11;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      check("t5:first_gnt", 64'(gnt), 64'd1);
      run_xfer(0, ADDR0, 4, 2'b11, "t5b");

`ifdef QSPI_ARB_TIMEOUT_EN
      // 6: engine never finishes -> abort/error 16 cycles after WAIT_DONE entry
      req = 2'b01;
      tick();
      check("t6:gnt", 64'(gnt), 64'd1);
      tick();
      repeat (15) tick();
      check("t6:no_early_abort", 64'(eng_abort), 64'd0);
      tick();
      check("t6:abort", 64'(eng_abort),   64'd1);
      check("t6:err",   64'(timeout_err), 64'd1);
      check("t6:ack",   64'(ack),         64'd1);
      req = 2'b00;
      tick();
      check("t6:abort_low", 64'(eng_abort), 64'd0);
      check("t6:gnt_low",   64'(gnt),       64'd0);
`else
      check("abort_never", 64'(abort_seen), 64'd0);
`endif

      check("gnt_never_two_hot", 64'(two_hot_seen), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
